// File: rtl/fir_pkg.sv
// Shared constants, FSM state type and sizing helper for the parametrised FIR engine.
package fir_pkg;

  localparam int ADDR_AP_CTRL  = 'h00;
  localparam int ADDR_DATA_LEN = 'h10;
  localparam int ADDR_TAP_BASE = 'h20;

  localparam int AP_START_BIT = 0;
  localparam int AP_DONE_BIT  = 1;
  localparam int AP_IDLE_BIT  = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_MAC  = 2'd2,
    S_OUT  = 2'd3
  } fsm_state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fir_axilite_regs.sv
// AXI-Lite slave for the FIR: tap/length register file and ap_start/ap_done/ap_idle
// bookkeeping. Taps and length are writable only while the engine is idle.
module fir_axilite_regs
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pTAP_NUM    = 11
) (
  input  logic                                   axis_clk,
  input  logic                                   axis_rst,
  input  logic                                   awvalid,
  input  logic [pADDR_WIDTH-1:0]                 awaddr,
  output logic                                   awready,
  input  logic                                   wvalid,
  input  logic [pDATA_WIDTH-1:0]                 wdata,
  output logic                                   wready,
  input  logic                                   arvalid,
  input  logic [pADDR_WIDTH-1:0]                 araddr,
  output logic                                   arready,
  output logic                                   rvalid,
  output logic [pDATA_WIDTH-1:0]                 rdata,
  input  logic                                   rready,
  output logic [pTAP_NUM-1:0][pDATA_WIDTH-1:0]   taps,
  output logic [pDATA_WIDTH-1:0]                 data_len,
  output logic                                   ap_start,
  input  logic                                   start_ack,
  input  logic                                   done_set
);

  logic [pTAP_NUM-1:0][pDATA_WIDTH-1:0] taps_q, taps_d;
  logic [pDATA_WIDTH-1:0] len_q, len_d;
  logic ap_start_q, ap_start_d;
  logic ap_done_q, ap_done_d;
  logic ap_idle_q, ap_idle_d;
  logic wack_q, wack_d;
  logic arready_q, arready_d;
  logic rvalid_q, rvalid_d;
  logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [pDATA_WIDTH-1:0] rd_val;
  logic wr_en, rd_en;

  always_comb begin
    rd_val = '0;
    if (araddr == pADDR_WIDTH'(ADDR_AP_CTRL)) begin
      rd_val[AP_START_BIT] = ap_start_q;
      rd_val[AP_DONE_BIT]  = ap_done_q;
      rd_val[AP_IDLE_BIT]  = ap_idle_q;
    end else if (araddr == pADDR_WIDTH'(ADDR_DATA_LEN)) begin
      rd_val = len_q;
    end
    for (int k = 0; k < pTAP_NUM; k++)
      if (araddr == pADDR_WIDTH'(ADDR_TAP_BASE + 4*k)) rd_val = taps_q[k];
  end

  always_comb begin
    // Address and data are only ever accepted together, in one shared pulse.
    wack_d    = awvalid && wvalid && !wack_q;
    wr_en     = awvalid && wvalid && wack_q;
    arready_d = arvalid && !arready_q && !rvalid_q;
    rd_en     = arvalid && arready_q;
    taps_d     = taps_q;
    len_d      = len_q;
    ap_start_d = ap_start_q;
    ap_done_d  = ap_done_q;
    ap_idle_d  = ap_idle_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;

    if (rvalid_q && rready) rvalid_d = 1'b0;
    if (rd_en) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val;
      if (araddr == pADDR_WIDTH'(ADDR_AP_CTRL)) ap_done_d = 1'b0;
    end

    if (wr_en) begin
      if (awaddr == pADDR_WIDTH'(ADDR_AP_CTRL)) begin
        if (wdata[AP_START_BIT] && ap_idle_q) begin
          ap_start_d = 1'b1;
          ap_done_d  = 1'b0;
        end
      end else if (ap_idle_q) begin
        if (awaddr == pADDR_WIDTH'(ADDR_DATA_LEN)) len_d = wdata;
        for (int k = 0; k < pTAP_NUM; k++)
          if (awaddr == pADDR_WIDTH'(ADDR_TAP_BASE + 4*k)) taps_d[k] = wdata;
      end
    end

    if (start_ack) begin
      ap_start_d = 1'b0;
      ap_idle_d  = 1'b0;
    end
    // Completion beats a same-cycle read clear so the done event is never lost.
    if (done_set) begin
      ap_done_d = 1'b1;
      ap_idle_d = 1'b1;
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      taps_q     <= '0;
      len_q      <= '0;
      ap_start_q <= 1'b0;
      ap_done_q  <= 1'b0;
      ap_idle_q  <= 1'b1;
      wack_q     <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      taps_q     <= taps_d;
      len_q      <= len_d;
      ap_start_q <= ap_start_d;
      ap_done_q  <= ap_done_d;
      ap_idle_q  <= ap_idle_d;
      wack_q     <= wack_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  assign awready  = wack_q;
  assign wready   = wack_q;
  assign arready  = arready_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign taps     = taps_q;
  assign data_len = len_q;
  assign ap_start = ap_start_q;

endmodule

// File: rtl/fir_axis_param.sv
// Parametrised AXI-Stream FIR with one shared MAC (one tap per cycle).
// Define FIR_SATURATE_EN to clamp outputs to the signed data range instead of wrapping.
module fir_axis_param
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pTAP_NUM    = 11,
  parameter int pACC_WIDTH  = 2*pDATA_WIDTH+5
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   awvalid,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  output logic                   awready,
  input  logic                   wvalid,
  input  logic [pDATA_WIDTH-1:0] wdata,
  output logic                   wready,
  input  logic                   arvalid,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   arready,
  output logic                   rvalid,
  output logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   rready,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  output logic                   sm_tvalid,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  input  logic                   sm_tready
);

  localparam int KW = cnt_width(pTAP_NUM);

  logic [pTAP_NUM-1:0][pDATA_WIDTH-1:0] taps;
  logic [pDATA_WIDTH-1:0] data_len;
  logic ap_start, start_ack, done_set;

  fir_axilite_regs #(
    .pADDR_WIDTH(pADDR_WIDTH),
    .pDATA_WIDTH(pDATA_WIDTH),
    .pTAP_NUM   (pTAP_NUM)
  ) u_regs (
    .axis_clk (axis_clk),
    .axis_rst (axis_rst),
    .awvalid  (awvalid),
    .awaddr   (awaddr),
    .awready  (awready),
    .wvalid   (wvalid),
    .wdata    (wdata),
    .wready   (wready),
    .arvalid  (arvalid),
    .araddr   (araddr),
    .arready  (arready),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .rready   (rready),
    .taps     (taps),
    .data_len (data_len),
    .ap_start (ap_start),
    .start_ack(start_ack),
    .done_set (done_set)
  );

  fsm_state_e state_q, state_d;
  logic [pTAP_NUM-1:0][pDATA_WIDTH-1:0] x_q, x_d;
  logic signed [pACC_WIDTH-1:0] acc_q, acc_d, acc_sum;
  logic [KW-1:0] k_q, k_d;
  logic [pDATA_WIDTH-1:0] cnt_q, cnt_d;
  logic tlast_q, tlast_d;
  logic ss_tready_q, ss_tready_d;
  logic sm_tvalid_q, sm_tvalid_d;
  logic sm_tlast_q, sm_tlast_d;
  logic [pDATA_WIDTH-1:0] sm_tdata_q, sm_tdata_d;
  logic signed [pDATA_WIDTH-1:0] tap_sel, x_sel;
  logic signed [2*pDATA_WIDTH-1:0] prod;

  function automatic logic [pDATA_WIDTH-1:0] out_fmt(input logic signed [pACC_WIDTH-1:0] a);
`ifdef FIR_SATURATE_EN
    logic [pACC_WIDTH-pDATA_WIDTH:0] hi;
    hi = a[pACC_WIDTH-1:pDATA_WIDTH-1];
    if (hi == '0 || hi == '1) return a[pDATA_WIDTH-1:0];
    else if (a[pACC_WIDTH-1]) return {1'b1, {(pDATA_WIDTH-1){1'b0}}};
    else return {1'b0, {(pDATA_WIDTH-1){1'b1}}};
`else
    return a[pDATA_WIDTH-1:0];
`endif
  endfunction

  always_comb begin
    tap_sel = '0;
    x_sel   = '0;
    for (int i = 0; i < pTAP_NUM; i++)
      if (k_q == KW'(i)) begin
        tap_sel = taps[i];
        x_sel   = x_q[i];
      end
    prod    = tap_sel * x_sel;
    acc_sum = acc_q + pACC_WIDTH'(prod);
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    acc_d      = acc_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    tlast_d    = tlast_q;
    sm_tdata_d = sm_tdata_q;
    sm_tlast_d = sm_tlast_q;
    start_ack  = 1'b0;
    done_set   = 1'b0;
    case (state_q)
      S_IDLE: if (ap_start) begin
        x_d       = '0;
        cnt_d     = '0;
        start_ack = 1'b1;
        state_d   = S_LOAD;
      end
      S_LOAD: if (ss_tvalid && ss_tready_q) begin
        x_d     = {x_q[pTAP_NUM-2:0], ss_tdata};
        tlast_d = ss_tlast;
        acc_d   = '0;
        k_d     = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_d = acc_sum;
        k_d   = k_q + KW'(1);
        if (k_q == KW'(pTAP_NUM-1)) begin
          state_d    = S_OUT;
          sm_tdata_d = out_fmt(acc_sum);
          // Length 0 means unbounded: only the input tlast can end the run.
          sm_tlast_d = tlast_q || (data_len != '0 && cnt_q + pDATA_WIDTH'(1) == data_len);
        end
      end
      S_OUT: if (sm_tready && sm_tvalid_q) begin
        cnt_d      = cnt_q + pDATA_WIDTH'(1);
        sm_tlast_d = 1'b0;
        if (sm_tlast_q) begin
          done_set = 1'b1;
          state_d  = S_IDLE;
        end else begin
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ss_tready_d = (state_d == S_LOAD);
    sm_tvalid_d = (state_d == S_OUT);
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      acc_q       <= '0;
      k_q         <= '0;
      cnt_q       <= '0;
      tlast_q     <= 1'b0;
      ss_tready_q <= 1'b0;
      sm_tvalid_q <= 1'b0;
      sm_tlast_q  <= 1'b0;
      sm_tdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      tlast_q     <= tlast_d;
      ss_tready_q <= ss_tready_d;
      sm_tvalid_q <= sm_tvalid_d;
      sm_tlast_q  <= sm_tlast_d;
      sm_tdata_q  <= sm_tdata_d;
    end
  end

  assign ss_tready = ss_tready_q;
  assign sm_tvalid = sm_tvalid_q;
  assign sm_tdata  = sm_tdata_q;
  assign sm_tlast  = sm_tlast_q;

endmodule

// File: tb/tb_fir_axis_param.sv
// Randomised bench for fir_axis_param against a direct-convolution reference model.
module tb_fir_axis_param;
  localparam int AW = 12, DW = 32, NT = 11;

  logic axis_clk = 1'b0, axis_rst = 1'b1;
  logic awvalid = 0, wvalid = 0, arvalid = 0, rready = 0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [DW-1:0] wdata = '0, ss_tdata = '0;
  logic ss_tvalid = 0, ss_tlast = 0, sm_tready = 0;
  logic awready, wready, arready, rvalid, ss_tready, sm_tvalid, sm_tlast;
  logic [DW-1:0] rdata, sm_tdata;

  always #5 axis_clk = ~axis_clk;

  fir_axis_param #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pTAP_NUM(NT)) dut (
    .axis_clk(axis_clk), .axis_rst(axis_rst),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wready(wready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rready(rready),
    .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
    .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready)
  );

  int n_cmp = 0, n_bad = 0;
  logic [DW-1:0] tap_m [NT];
  logic [DW-1:0] samp [$];
  logic [DW-1:0] rv;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // y[n] = sum_k h[k]*x[n-k], history starts at zero for every run.
  function automatic logic [DW-1:0] ref_out(input int n);
    logic signed [68:0] acc, hv, xv;
    logic signed [68:0] maxv, minv;
    acc  = '0;
    maxv = 69'sd2147483647;
    minv = -69'sd2147483648;
    for (int k = 0; k < NT; k++)
      if (n - k >= 0) begin
        hv  = 69'($signed(tap_m[k]));
        xv  = 69'($signed(samp[n-k]));
        acc = acc + hv * xv;
      end
`ifdef FIR_SATURATE_EN
    if (acc > maxv) return 32'h7FFF_FFFF;
    if (acc < minv) return 32'h8000_0000;
`endif
    return acc[DW-1:0];
  endfunction

  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok = 0;
    awaddr = a; wdata = d; awvalid = 1; wvalid = 1;
    for (int n = 0; n < 20; n++) begin
      @(posedge axis_clk); #1;
      if (awready && wready) begin ok = 1; break; end
    end
    if (!ok) chk("aw_handshake_timeout", 0, 1);
    else begin @(posedge axis_clk); #1; end
    awvalid = 0; wvalid = 0;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
    bit ok = 0;
    araddr = a; arvalid = 1; d = '0;
    for (int n = 0; n < 20; n++) begin
      @(posedge axis_clk); #1;
      if (arready) begin ok = 1; break; end
    end
    if (!ok) begin
      chk("ar_handshake_timeout", 0, 1);
      arvalid = 0;
    end else begin
      @(posedge axis_clk); #1;
      arvalid = 0;
      chk("rvalid", rvalid, 1);
      d = rdata;
      rready = 1;
      @(posedge axis_clk); #1;
      rready = 0;
    end
  endtask

  task automatic prog_taps();
    for (int k = 0; k < NT; k++) axi_write(AW'('h20 + 4*k), tap_m[k]);
  endtask

  task automatic rand_taps(input bit full);
    for (int k = 0; k < NT; k++)
      tap_m[k] = full ? $urandom : ($urandom_range(0, 200) - 100);
    prog_taps();
  endtask

  task automatic fill(input int n);
    samp.delete();
    for (int i = 0; i < n; i++)
      samp.push_back(($urandom_range(0, 1) == 1) ? $urandom : ($urandom_range(0, 60) - 30));
  endtask

  function automatic int n_outs(input int len, input int tl);
    int n;
    n = (tl >= 0) ? tl + 1 : len;
    if (len != 0 && len < n) n = len;
    return n;
  endfunction

  task automatic drive(input int n, input int tl, input bit rnd);
    int w;
    for (int i = 0; i < n; i++) begin
      if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge axis_clk); #1; end
      ss_tvalid = 1; ss_tdata = samp[i]; ss_tlast = (i == tl);
      w = 0;
      while (!ss_tready && w < 500) begin @(posedge axis_clk); #1; w++; end
      if (w >= 500) begin chk("ss_tready_timeout", 0, 1); break; end
      @(posedge axis_clk); #1;
      ss_tvalid = 0; ss_tlast = 0;
    end
    ss_tvalid = 0; ss_tlast = 0;
  endtask

  task automatic collect(input int n, input bit rnd, input bit hold);
    int got = 0, cyc = 0;
    logic [DW-1:0] d;
    while (got < n && cyc < 5000) begin
      sm_tready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (hold && sm_tvalid) begin
        sm_tready = 0; d = sm_tdata;
        for (int c = 0; c < 20; c++) begin @(posedge axis_clk); #1; end
        chk("hold_tvalid", sm_tvalid, 1);
        chk("hold_tdata", sm_tdata, d);
        chk("hold_ss_tready", ss_tready, 0);
        hold = 0; sm_tready = 1;
      end
      if (sm_tvalid && sm_tready) begin
        chk($sformatf("y[%0d]", got), sm_tdata, ref_out(got));
        chk($sformatf("tlast[%0d]", got), sm_tlast, got == n - 1);
        got++;
      end
      @(posedge axis_clk); #1; cyc++;
    end
    sm_tready = 0;
    chk("out_count", got, n);
    repeat (3) begin @(posedge axis_clk); #1; end
    chk("no_extra_out", sm_tvalid, 0);
  endtask

  task automatic run(input int len, input int tl, input bit rnd, input bit hold);
    int n;
    n = n_outs(len, tl);
    fork
      drive(n, tl, rnd);
      collect(n, rnd, hold);
    join
    axi_read('h00, rv); chk("ctrl_after_run", rv, 'h6);
  endtask

  task automatic go(input int len);
    axi_write('h10, len);
    axi_write('h00, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    int len, tl;
    repeat (3) @(posedge axis_clk);
    #1;
    chk("rst_ss_tready", ss_tready, 0);
    chk("rst_sm_bus", {sm_tvalid, sm_tlast, sm_tdata}, 0);
    chk("rst_axil", {awready, wready, arready, rvalid, rdata}, 0);
    axis_rst = 0;
    @(posedge axis_clk); #1;
    axi_read('h00, rv); chk("ctrl_reset", rv, 'h4);
    axi_read('h10, rv); chk("len_reset", rv, 0);
    axi_read('h20, rv); chk("tap0_reset", rv, 0);

    // Impulse response reproduces the taps in order.
    tap_m = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    prog_taps();
    axi_write('h10, 11);
    for (int k = 0; k < NT; k++) begin
      axi_read(AW'('h20 + 4*k), rv); chk($sformatf("tap_rb[%0d]", k), rv, tap_m[k]);
    end
    axi_read('h10, rv); chk("len_rb", rv, 11);
    samp.delete(); samp.push_back(1);
    for (int i = 0; i < 10; i++) samp.push_back(0);
    axi_write('h00, 1);
    run(11, -1, 0, 0);
    axi_read('h00, rv); chk("ctrl_second_read", rv, 'h4);

    // Writes while busy are dropped; registers stay readable.
    rand_taps(0);
    go(4);
    axi_write('h20, 32'h1234);
    axi_read('h20, rv); chk("busy_tap_write", rv, tap_m[0]);
    axi_write('h00, 1);
    axi_read('h00, rv); chk("busy_start_write", rv, 0);
    axi_read('h10, rv); chk("busy_len_read", rv, 4);
    fill(4);
    run(4, -1, 1, 0);

    // Early termination on tlast plus output backpressure.
    rand_taps(1);
    fill(5);
    go(600);
    run(600, 4, 0, 1);

    // Random runs, including an unbounded length ended only by tlast.
    for (int r = 0; r < 5; r++) begin
      rand_taps(r[0]);
      len = (r == 4) ? 0 : $urandom_range(1, 14);
      tl  = (r == 4) ? 6 : (($urandom_range(0, 1) == 1) ? $urandom_range(0, 16) : -1);
      fill(n_outs(len, tl));
      go(len);
      run(len, tl, 1, 0);
    end

    // Extreme values: exercise wrap or saturation.
    for (int k = 0; k < NT; k++) tap_m[k] = 32'h7FFF_FFFF;
    prog_taps();
    samp.delete();
    for (int i = 0; i < NT; i++) samp.push_back(32'h7FFF_FFFF);
    go(NT);
    run(NT, -1, 0, 0);

    // Reset in the middle of the MAC phase.
    go(0);
    begin
      int w = 0;
      while (!ss_tready && w < 100) begin @(posedge axis_clk); #1; w++; end
      chk("mid_rst_load_wait", ss_tready, 1);
    end
    ss_tvalid = 1; ss_tdata = 32'd5;
    @(posedge axis_clk); #1;
    ss_tvalid = 0;
    repeat (3) begin @(posedge axis_clk); #1; end
    axis_rst = 1;
    #1;
    chk("mid_rst_ss", ss_tready, 0);
    chk("mid_rst_sm", {sm_tvalid, sm_tlast, sm_tdata}, 0);
    chk("mid_rst_axil", {awready, wready, arready, rvalid, rdata}, 0);
    @(posedge axis_clk); #1;
    axis_rst = 0;
    @(posedge axis_clk); #1;
    axi_read('h00, rv); chk("mid_rst_ctrl", rv, 'h4);
    axi_read('h28, rv); chk("mid_rst_tap2", rv, 0);
    axi_read('h10, rv); chk("mid_rst_len", rv, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
